// File: rtl/cdecv_sequencer_if.sv
// Bus bundle between the CDECV microsequencer and its datapath/memory.
// master = sequencer side (drives selects), slave = datapath/environment side.
interface cdecv_sequencer_if #(
    parameter int STATE_W = 5
);
    logic [7:0]         I;
    logic [2:0]         SZCy;
    logic               mem_ready;
    logic [STATE_W-1:0] state;
    logic [2:0]         xsrc;
    logic [9:0]         xdst;
    logic [4:0]         aluop;
    logic               we;
    logic               end_sq;
    logic               halt;

    modport master (
        input  I, SZCy, mem_ready,
        output state, xsrc, xdst, aluop, we, end_sq, halt
    );

    modport slave (
        output I, SZCy, mem_ready,
        input  state, xsrc, xdst, aluop, we, end_sq, halt
    );
endinterface

// File: rtl/cdecv_sequencer.sv
// CDECV microsequencer: fetch/decode/execute walker driving datapath selects.
// Optional conditional jumps (opcode 5) are enabled by defining CDECV_JCC_EN.
//
// state | code | meaning
// RST   |  0   | reset, idle one cycle
// F0    |  1   | PC -> MA,R ; R = PC+1
// F1    |  2   | R -> PC
// F2    |  3   | RD -> I (waits on mem_ready)
// DEC   |  4   | decode opcode
// MV0   |  5   | register move
// A0    |  6   | PC -> MA,R ; R = PC+1 (operand byte)
// A1    |  7   | R -> PC
// A2    |  8   | operand byte RD -> T / MA / PC (waits on mem_ready)
// LD0   |  9   | memory read of load data (waits on mem_ready)
// LD1   | 10   | RD -> destination register
// ST0   | 11   | source register -> WD, write strobe
// ST1   | 12   | store complete
// HLT   | 13   | halted until reset
module cdecv_sequencer #(
    parameter int ADRS_BYTES = 1,
    parameter int STATE_W    = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    cdecv_sequencer_if.master bus
);
    typedef enum logic [3:0] {
        RST = 4'd0,  F0  = 4'd1,  F1  = 4'd2,  F2  = 4'd3,
        DEC = 4'd4,  MV0 = 4'd5,  A0  = 4'd6,  A1  = 4'd7,
        A2  = 4'd8,  LD0 = 4'd9,  LD1 = 4'd10, ST0 = 4'd11,
        ST1 = 4'd12, HLT = 4'd13
    } state_t;

    localparam logic [2:0] XS_PC = 3'd0;
    localparam logic [2:0] XS_RD = 3'd4;
    localparam logic [2:0] XS_R  = 3'd5;
    localparam logic [2:0] XS_FF = 3'd7;

    localparam logic [9:0] XD_NONE = 10'h000;
    localparam logic [9:0] XD_PC   = 10'h001;
    localparam logic [9:0] XD_MA   = 10'h010;
    localparam logic [9:0] XD_WD   = 10'h020;
    localparam logic [9:0] XD_I    = 10'h040;
    localparam logic [9:0] XD_T    = 10'h080;
    localparam logic [9:0] XD_R    = 10'h100;

    localparam logic [4:0] ALU_ZERO = 5'b00000;
    localparam logic [4:0] ALU_INC  = 5'b01110;

    state_t     state_q, state_d;
    logic       hi_done_q, hi_done_d;
    logic [3:0] op;
    logic       is_jcc;
    logic       jcc_taken;
    logic       last_byte;
    logic [2:0] xsrc;
    logic [9:0] xdst;
    logic [4:0] aluop;
    logic       we, end_sq, halt;

    assign op        = bus.I[7:4];
    assign last_byte = (ADRS_BYTES == 1) || hi_done_q;

`ifdef CDECV_JCC_EN
    logic jcc_cond;
    always_comb begin
        jcc_cond = 1'b1;
        case (bus.I[1:0])
            2'b01:   jcc_cond = bus.SZCy[1];
            2'b10:   jcc_cond = bus.SZCy[0];
            2'b11:   jcc_cond = bus.SZCy[2];
            default: jcc_cond = 1'b1;
        endcase
    end
    assign is_jcc    = (op == 4'h5);
    assign jcc_taken = jcc_cond ^ bus.I[2];
`else
    logic unused_szcy;
    assign unused_szcy = ^bus.SZCy;
    assign is_jcc      = 1'b0;
    assign jcc_taken   = 1'b0;
`endif

    // Register field 00 means "no register": FF on the source side, nothing on the destination side.
    function automatic logic [2:0] reg_src(input logic [1:0] f);
        return (f == 2'b00) ? XS_FF : {1'b0, f};
    endfunction

    function automatic logic [9:0] reg_dst(input logic [1:0] f);
        return (f == 2'b00) ? XD_NONE : (10'd1 << f);
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= RST;
            hi_done_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            hi_done_q <= hi_done_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        hi_done_d = hi_done_q;
        xsrc      = XS_FF;
        xdst      = XD_NONE;
        aluop     = ALU_ZERO;
        we        = 1'b0;
        end_sq    = 1'b0;
        halt      = 1'b0;
        case (state_q)
            RST: state_d = F0;
            F0, A0: begin
                xsrc    = XS_PC;
                xdst    = XD_MA | XD_R;
                aluop   = ALU_INC;
                state_d = (state_q == F0) ? F1 : A1;
            end
            F1, A1: begin
                xsrc    = XS_R;
                xdst    = XD_PC;
                state_d = (state_q == F1) ? F2 : A2;
            end
            F2: begin
                xsrc = XS_RD;
                if (bus.mem_ready) begin
                    xdst    = XD_I;
                    state_d = DEC;
                end
            end
            DEC: begin
                if (op == 4'h1) begin
                    state_d = MV0;
                end else if (op == 4'h2 || op == 4'h3 || op == 4'h4 || is_jcc) begin
                    state_d = A0;
                end else if (op == 4'hF) begin
                    state_d = HLT;
                end else begin
                    end_sq  = 1'b1;
                    state_d = F0;
                end
            end
            MV0: begin
                xsrc    = reg_src(bus.I[3:2]);
                xdst    = reg_dst(bus.I[1:0]);
                end_sq  = 1'b1;
                state_d = F0;
            end
            A2: begin
                xsrc = XS_RD;
                if (bus.mem_ready) begin
                    if (!last_byte) begin
                        xdst      = XD_T;
                        hi_done_d = 1'b1;
                        state_d   = A0;
                    end else if (op == 4'h2 || op == 4'h3) begin
                        xdst    = XD_MA;
                        state_d = (op == 4'h2) ? LD0 : ST0;
                    end else begin
                        // Untaken Jcc still consumed its operand, so PC is already past it.
                        if (op == 4'h4 || jcc_taken) xdst = XD_PC;
                        end_sq  = 1'b1;
                        state_d = F0;
                    end
                end
            end
            LD0: begin
                xsrc = XS_RD;
                if (bus.mem_ready) state_d = LD1;
            end
            LD1: begin
                xsrc    = XS_RD;
                xdst    = reg_dst(bus.I[1:0]);
                end_sq  = 1'b1;
                state_d = F0;
            end
            ST0: begin
                xsrc    = reg_src(bus.I[3:2]);
                xdst    = XD_WD;
                we      = 1'b1;
                state_d = ST1;
            end
            ST1: begin
                end_sq  = 1'b1;
                state_d = F0;
            end
            HLT: begin
                end_sq = 1'b1;
                halt   = 1'b1;
            end
            default: state_d = RST;
        endcase
        if (state_d == F0) hi_done_d = 1'b0;
    end

    assign bus.state  = STATE_W'(state_q);
    assign bus.xsrc   = xsrc;
    assign bus.xdst   = xdst;
    assign bus.aluop  = aluop;
    assign bus.we     = we;
    assign bus.end_sq = end_sq;
    assign bus.halt   = halt;
endmodule

// File: tb/tb_cdecv_sequencer.sv
// Bench for cdecv_sequencer: instruction-level model builds expected per-cycle outputs,
// checked against a 1-byte-address and a 2-byte-address instance.
module tb_cdecv_sequencer;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    cdecv_sequencer_if #(.STATE_W(5)) bus1();
    cdecv_sequencer_if #(.STATE_W(5)) bus2();

    cdecv_sequencer #(.ADRS_BYTES(1), .STATE_W(5)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
    cdecv_sequencer #(.ADRS_BYTES(2), .STATE_W(5)) dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));

`ifdef CDECV_JCC_EN
    localparam bit JCC_EN = 1'b1;
`else
    localparam bit JCC_EN = 1'b0;
`endif

    localparam logic [4:0] S_RST = 5'd0, S_F0 = 5'd1, S_F1 = 5'd2, S_F2 = 5'd3, S_DEC = 5'd4,
                           S_MV0 = 5'd5, S_A0 = 5'd6, S_A1 = 5'd7, S_A2 = 5'd8, S_LD0 = 5'd9,
                           S_LD1 = 5'd10, S_ST0 = 5'd11, S_ST1 = 5'd12, S_HLT = 5'd13;
    localparam logic [4:0] INC = 5'b01110;

    typedef struct packed {
        logic        mr;
        logic [7:0]  ins;
        logic [2:0]  fl;
        logic [25:0] exp;
    } cyc_t;

    cyc_t       q[$];
    int         n_chk = 0;
    int         n_pass = 0;
    int         sel = 1;
    logic [7:0] cur_i;
    logic [2:0] cur_f;

    function automatic logic [25:0] ev(input logic [4:0] st, input logic [2:0] xs, input logic [9:0] xd,
                                       input logic [4:0] al, input logic w, input logic es, input logic hl);
        return {st, xs, xd, al, w, es, hl};
    endfunction

    function automatic logic [2:0] srcf(input logic [1:0] f);
        return (f == 2'b00) ? 3'd7 : {1'b0, f};
    endfunction

    function automatic logic [9:0] dstf(input logic [1:0] f);
        return (f == 2'b00) ? 10'h000 : (10'd1 << f);
    endfunction

    task automatic check(input string name, input logic [25:0] act, input logic [25:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got {st,xs,xd,al,we,es,hl}=%h required %h", name, act, exp);
    endtask

    task automatic check_len(input string name, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: model cycles %0d required %0d", name, got, exp);
    endtask

    task automatic push(input logic [4:0] st, input logic [2:0] xs, input logic [9:0] xd, input logic [4:0] al,
                        input logic w, input logic es, input logic hl, input logic mr);
        cyc_t r;
        r.mr  = mr;
        r.ins = cur_i;
        r.fl  = cur_f;
        r.exp = ev(st, xs, xd, al, w, es, hl);
        q.push_back(r);
    endtask

    // Expected cycle-by-cycle behaviour of one instruction, from the instruction-level rules.
    task automatic gen(input logic [7:0] ins, input logic [2:0] fl, input int ab,
                       input int wf2, input int wa2, input int wld);
        logic [3:0] op;
        logic       c, jcc, mem, taken;
        op    = ins[7:4];
        cur_i = ins;
        cur_f = fl;
        jcc   = JCC_EN && (op == 4'h5);
        mem   = (op == 4'h2) || (op == 4'h3) || (op == 4'h4) || jcc;
        case (ins[1:0])
            2'b00:   c = 1'b1;
            2'b01:   c = fl[1];
            2'b10:   c = fl[0];
            default: c = fl[2];
        endcase
        taken = (op == 4'h4) || (jcc && (c ^ ins[2]));
        push(S_F0, 3'd0, 10'h110, INC, 0, 0, 0, 1);
        push(S_F1, 3'd5, 10'h001, 5'd0, 0, 0, 0, 1);
        repeat (wf2) push(S_F2, 3'd4, 10'h000, 5'd0, 0, 0, 0, 0);
        push(S_F2, 3'd4, 10'h040, 5'd0, 0, 0, 0, 1);
        if (op == 4'h1) begin
            push(S_DEC, 3'd7, 10'h000, 5'd0, 0, 0, 0, 1);
            push(S_MV0, srcf(ins[3:2]), dstf(ins[1:0]), 5'd0, 0, 1, 0, 1);
        end else if (mem) begin
            push(S_DEC, 3'd7, 10'h000, 5'd0, 0, 0, 0, 1);
            for (int b = 0; b < ab; b++) begin
                push(S_A0, 3'd0, 10'h110, INC, 0, 0, 0, 1);
                push(S_A1, 3'd5, 10'h001, 5'd0, 0, 0, 0, 1);
                repeat (wa2) push(S_A2, 3'd4, 10'h000, 5'd0, 0, 0, 0, 0);
                if (b < ab - 1)                    push(S_A2, 3'd4, 10'h080, 5'd0, 0, 0, 0, 1);
                else if (op == 4'h2 || op == 4'h3) push(S_A2, 3'd4, 10'h010, 5'd0, 0, 0, 0, 1);
                else                               push(S_A2, 3'd4, taken ? 10'h001 : 10'h000, 5'd0, 0, 1, 0, 1);
            end
            if (op == 4'h2) begin
                repeat (wld) push(S_LD0, 3'd4, 10'h000, 5'd0, 0, 0, 0, 0);
                push(S_LD0, 3'd4, 10'h000, 5'd0, 0, 0, 0, 1);
                push(S_LD1, 3'd4, dstf(ins[1:0]), 5'd0, 0, 1, 0, 1);
            end else if (op == 4'h3) begin
                push(S_ST0, srcf(ins[3:2]), 10'h020, 5'd0, 1, 0, 0, 1);
                push(S_ST1, 3'd7, 10'h000, 5'd0, 0, 1, 0, 1);
            end
        end else if (op == 4'hF) begin
            push(S_DEC, 3'd7, 10'h000, 5'd0, 0, 0, 0, 1);
            repeat (100) push(S_HLT, 3'd7, 10'h000, 5'd0, 0, 1, 1, 1);
        end else begin
            push(S_DEC, 3'd7, 10'h000, 5'd0, 0, 1, 0, 1);
        end
    endtask

    task automatic drive(input cyc_t r);
        if (sel == 1) begin
            bus1.I = r.ins; bus1.SZCy = r.fl; bus1.mem_ready = r.mr;
        end else begin
            bus2.I = r.ins; bus2.SZCy = r.fl; bus2.mem_ready = r.mr;
        end
    endtask

    function automatic logic [25:0] actual();
        if (sel == 1)
            return {bus1.state, bus1.xsrc, bus1.xdst, bus1.aluop, bus1.we, bus1.end_sq, bus1.halt};
        return {bus2.state, bus2.xsrc, bus2.xdst, bus2.aluop, bus2.we, bus2.end_sq, bus2.halt};
    endfunction

    task automatic run(input string name);
        cyc_t r;
        int   k = 0;
        while (q.size() > 0) begin
            r = q.pop_front();
            @(posedge clk);
            #1 drive(r);
            @(negedge clk);
            check($sformatf("%s.c%0d", name, k), actual(), r.exp);
            k++;
        end
    endtask

    task automatic do_reset(input string name);
        @(negedge clk);
        rst_n = 1'b0;
        #1 check({name, ".rst_assert"}, actual(), ev(S_RST, 3'd7, 10'h000, 5'd0, 0, 0, 0));
        repeat (2) @(negedge clk);
        check({name, ".rst_hold"}, actual(), ev(S_RST, 3'd7, 10'h000, 5'd0, 0, 0, 0));
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus1.I = 8'h00; bus1.SZCy = 3'b000; bus1.mem_ready = 1'b1;
        bus2.I = 8'h00; bus2.SZCy = 3'b000; bus2.mem_ready = 1'b1;

        sel = 1;
        do_reset("ab1");
        gen(8'h1B, 3'b000, 1, 0, 0, 0); check_len("mov_len", q.size(), 5);  run("mov_bc");
        gen(8'h00, 3'b000, 1, 0, 0, 0); check_len("nop_len", q.size(), 4);  run("nop");
        gen(8'h10, 3'b000, 1, 0, 0, 0);                                    run("mov_none");
        gen(8'h21, 3'b000, 1, 0, 0, 2); check_len("ld_len", q.size(), 11);  run("ld_a_wait");
        gen(8'h34, 3'b000, 1, 1, 0, 0); check_len("st_len", q.size(), 10);  run("st_a_f2wait");
        gen(8'h40, 3'b000, 1, 0, 1, 0); check_len("jmp_len", q.size(), 8); run("jmp_a2wait");
        gen(8'h51, 3'b010, 1, 0, 0, 0); check_len("jz_len", q.size(), JCC_EN ? 7 : 4);  run("jz_taken");
        gen(8'h55, 3'b010, 1, 0, 0, 0); check_len("jnz_len", q.size(), JCC_EN ? 7 : 4); run("jnz_untaken");
        gen(8'h5A, 3'b010, 1, 0, 0, 0);                                    run("jc_untaken");
        gen(8'h5B, 3'b100, 1, 0, 0, 0);                                    run("js_taken");
        gen(8'hF0, 3'b000, 1, 0, 0, 0); check_len("hlt_len", q.size(), 104); run("halt");

        @(posedge clk);
        #3 rst_n = 1'b0;
        #1 check("halt_async_rst", actual(), ev(S_RST, 3'd7, 10'h000, 5'd0, 0, 0, 0));

        sel = 2;
        do_reset("ab2");
        gen(8'h34, 3'b000, 2, 0, 0, 0); check_len("st2_len", q.size(), 12);  run("st2_a");
        gen(8'h2E, 3'b000, 2, 0, 1, 0); check_len("ld2_len", q.size(), 14);  run("ld2_b_wait");
        gen(8'h40, 3'b000, 2, 0, 0, 0); check_len("jmp2_len", q.size(), 10); run("jmp2");
        gen(8'h51, 3'b010, 2, 0, 0, 0); check_len("jz2_len", q.size(), JCC_EN ? 10 : 4); run("jz2");
        gen(8'h1B, 3'b000, 2, 0, 0, 0);                                      run("mov2");

        // Stop in ST0 and reset while we is high.
        gen(8'h37, 3'b000, 2, 0, 0, 0);
        void'(q.pop_back());
        run("st2_abort");
        #2 rst_n = 1'b0;
        #1 check("st_abort_we", actual(), ev(S_RST, 3'd7, 10'h000, 5'd0, 0, 0, 0));
        @(posedge clk);
        #1 check("st_abort_no_st1", actual(), ev(S_RST, 3'd7, 10'h000, 5'd0, 0, 0, 0));
        @(negedge clk);
        rst_n = 1'b1;
        gen(8'h00, 3'b000, 2, 0, 0, 0); run("nop_after_abort");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/cdecv_sequencer.md
# cdecv_sequencer

Parametrised microsequencer for the CDECV controller. It holds the control state register, walks fetch/decode/execute sequences and drives the datapath selects (xsrc, xdst, aluop, we) each cycle. Relative to the single-byte-address combinational decoder it replaces, it adds:
- configurable operand-address width;
- memory wait states;
- optional conditional jumps.

## Interface
Parameters:
- ADRS_BYTES, 1, operand address bytes fetched by LD/ST/JMP/Jcc; legal values 1 or 2.
- STATE_W, 5, width of the exported state code.

Ports:
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- I  in  8  instruction register contents (valid from DEC onward).
- SZCy  in  3  flags {S,Z,Cy} from FLG register.
- mem_ready  in  1  memory read data (RD) valid this cycle.
- state  out  STATE_W  current state code (debug/monitor).
- xsrc  out  3  bus source: PC=0, A=1, B=2, C=3, RD=4, R=5, FLG=6, FF=7.
- xdst  out  10  one-hot bus destinations {FLG,R,T,I,WD,MA,C,B,A,PC}, bit 0 = PC.
- aluop  out  5  ZERO=00000, INC=01110.
- we  out  1  memory write strobe.
- end_sq  out  1  last cycle of an instruction.
- halt  out  1  processor halted.

## Operation
Opcode I[7:4]: 1 MOV, 2 LD, 3 ST, 4 JMP, 5 Jcc, F HALT, others NOP. Register fields: 01=A, 10=B, 11=C, 00=none. Unlisted outputs are aluop=ZERO, we=0, end_sq=0.

States, with outputs as (xsrc, xdst, aluop) -> next state:
- RST: FF, none, ZERO -> F0.
- F0: PC, MA|R, INC -> F1.
- F1: R, PC -> F2.
- F2: RD, I -> DEC when mem_ready, else hold with xdst=none.
- DEC: FF, none. MOV -> MV0; LD/ST/JMP/Jcc -> A0; HALT -> HLT; NOP -> F0 with end_sq=1.
- MV0: src field I[3:2], dst field I[1:0], end_sq=1 -> F0. A 00 field gives xsrc=FF / xdst=none.
- A0: PC, MA|R, INC -> A1.
- A1: R, PC -> A2.
- A2 (waits on mem_ready, xdst=none while waiting):
  - ADRS_BYTES=2, first byte: RD -> T, set internal hi_done -> A0.
  - Final byte, LD/ST: RD -> MA -> LD0/ST0.
  - Final byte, JMP or taken Jcc: RD -> PC, end_sq=1 -> F0.
  - Final byte, untaken Jcc: xdst=none, end_sq=1 -> F0.
- LD0: RD, none; waits on mem_ready -> LD1.
- LD1: RD -> dst I[1:0], end_sq=1 -> F0.
- ST0: sreg I[3:2] -> WD, we=1 -> ST1. An sreg field of 00 drives xsrc=FF.
- ST1: FF, none, end_sq=1 -> F0.
- HLT: FF, none, end_sq=1, halt=1. Absorbing; only reset exits.

Jcc conditions:
- Condition select I[1:0]: 00 always, 01 Z, 10 Cy, 11 S.
- I[2]=1 inverts the condition.
- SZCy is sampled in A2 on the final-byte cycle.
- Taken and untaken Jcc consume the same operand bytes, so PC always advances past the operand.

## Timing
- Reset: asynchronous assertion forces state=RST, hi_done=0. Outputs follow RST immediately: xsrc=FF, xdst=0, aluop=0, we=0, end_sq=0, halt=0.
- Reset release: the first rising edge moves the sequencer to F0.
- Reset mid-instruction aborts it: no further we and no partial register write.
- All outputs are a combinational function of the state register (plus I and SZCy where noted). There are no output registers.
- Cycle counts with zero wait states, RST excluded:
  - NOP 4, MOV 5.
  - LD 9+3(ADRS_BYTES−1), ST 9+3(ADRS_BYTES−1).
  - JMP/Jcc 7+3(ADRS_BYTES−1).
- Each cycle mem_ready is low in F2, A2 or LD0 adds exactly one cycle. No bus destination is loaded during those wait cycles.
- we is high for exactly one cycle per ST and never in any other state.
- hi_done clears on entry to F0.

## Configuration
- CDECV_JCC_EN defined: opcode 5 decodes as Jcc as described.
- CDECV_JCC_EN undefined: opcode 5 is a NOP (DEC -> F0, end_sq=1). SZCy is unused.

## Test plan
- Reset, then instruction 0x1B (MOV B,C), mem_ready=1: state sequence RST,F0,F1,F2,DEC,MV0. In MV0, xsrc=2, xdst=0x008, end_sq=1.
- Instruction 0x21 (LD, dst A), ADRS_BYTES=1, mem_ready low 2 cycles in LD0: instruction takes 11 cycles. LD1 drives xsrc=4, xdst=0x002.
- Instruction 0x34 (ST A), ADRS_BYTES=2: A2 first loads T (xdst=0x080), then MA (0x010). we=1 for one cycle with xsrc=1, xdst=0x020.
- Jcc with CDECV_JCC_EN defined:
  - 0x51 with SZCy=3'b010: final A2 has xdst=0x001 (taken).
  - 0x55 with the same flags: xdst=0 (not taken).
  - Both take 7 cycles.
- Instruction 0xF0: reaches HLT with halt=1 held for 100 cycles. Pulsing rst_n low mid-cycle drops halt asynchronously and returns state to RST.
- Reset asserted during ST0 with we=1: we falls immediately and no ST1 follows.
